// File: rtl/clock_meas_pkg.sv
// clock_meas_pkg: shared state encoding and default sizing for the clock period meter
package clock_meas_pkg;
  localparam int DEF_WIDTH = 23;
  localparam int DEF_TIMEOUT = 8388607;
  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEASURE} meas_state_t;
endpackage

// File: rtl/clock_period_meter_if.sv
// clock_period_meter_if: waveform input, soft clear and measurement results
interface clock_period_meter_if
  import clock_meas_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic sig_in;
  logic clear;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_count;
  logic valid;
  logic stalled;
  modport master(output sig_in, clear, input period, high_count, valid, stalled);
  modport slave(input sig_in, clear, output period, high_count, valid, stalled);
endinterface

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser with an edge register producing level and rise
module sync_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic sig_in,
  output logic level,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clock_in) begin
    if (reset) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {sig_in, s1, s2};
  end
  assign level = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow waveform in clock_in cycles
module clock_period_meter
  import clock_meas_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clock_in,
  input logic reset,
  clock_period_meter_if.slave bus
);
  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  meas_state_t state, state_d;
  logic [WIDTH-1:0] cnt, cnt_d, hcnt, hcnt_d, period_q, high_q;
  logic valid_q, stalled_q, capture, timeout, level, rise;
  logic [1:0] warm;
  sync_edge_detect u_sync (
    .clock_in(clock_in),
    .reset(reset),
    .sig_in(bus.sig_in),
    .level(level),
    .rise(rise)
  );
  // the synchroniser holds reset zeros for two cycles; only trust a low level once real samples arrive
  wire primed = warm[1];
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    hcnt_d = hcnt;
    capture = 1'b0;
    timeout = 1'b0;
    if (state == WAIT_LOW) begin
      cnt_d = '0;
      hcnt_d = '0;
      state_d = (primed && !level) ? WAIT_RISE : WAIT_LOW;
    end else if (rise) begin
      cnt_d = ONE;
      hcnt_d = ONE;
      capture = state == MEASURE;
      state_d = MEASURE;
    end else if (cnt == TMO) begin
      cnt_d = '0;
      hcnt_d = '0;
      timeout = 1'b1;
      state_d = WAIT_LOW;
    end else begin
      cnt_d = cnt + ONE;
      hcnt_d = hcnt + WIDTH'(level);
    end
    if (bus.clear) begin
      state_d = WAIT_LOW;
      cnt_d = '0;
      hcnt_d = '0;
      capture = 1'b0;
      timeout = 1'b0;
    end
  end
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state <= WAIT_LOW;
      warm <= 2'b00;
      cnt <= '0;
      hcnt <= '0;
      period_q <= '0;
      high_q <= '0;
      valid_q <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state <= state_d;
      warm <= {warm[0], 1'b1};
      cnt <= cnt_d;
      hcnt <= hcnt_d;
      valid_q <= capture;
      period_q <= capture ? cnt : period_q;
      high_q <= capture ? hcnt : high_q;
      stalled_q <= capture ? 1'b0 : (timeout ? 1'b1 : stalled_q);
    end
  end
  assign bus.period = period_q;
  assign bus.high_count = high_q;
  assign bus.valid = valid_q;
  assign bus.stalled = stalled_q;
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed table and corner-case sequences for clock_period_meter
module tb_clock_period_meter;
  localparam int W = 8;
  localparam int TMO = 20;
  typedef struct {
    int hi;
    int lo;
    int exp_p;
    int exp_h;
  } vec_t;
  logic clock_in = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_fail = 0;
  clock_period_meter_if #(.WIDTH(W)) bus ();
  clock_period_meter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clock_in(clock_in),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock_in = ~clock_in;
  task automatic cyc(input logic s, input logic c, input logic r);
    bus.sig_in = s;
    bus.clear = c;
    reset = r;
    @(posedge clock_in);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic start();
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask
  function automatic logic wv(input int k, input int hi, input int p);
    return (k % p) < hi;
  endfunction
  initial begin
    vec_t tbl[6];
    int nv, p;
    tbl = '{'{3, 3, 6, 3}, '{5, 5, 10, 5}, '{1, 1, 2, 1}, '{2, 6, 8, 2}, '{4, 1, 5, 4}, '{1, 3, 4, 1}};
    bus.sig_in = 1'b0;
    bus.clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      p = tbl[i].hi + tbl[i].lo;
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("rst_period", int'(bus.period), 0);
      chk("rst_high", int'(bus.high_count), 0);
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_stalled", int'(bus.stalled), 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      nv = 0;
      for (int k = 0; k < 4 * p + 2; k++) begin
        cyc(wv(k, tbl[i].hi, p), 0, 0);
        if (bus.valid) begin
          nv++;
          chk("tbl_valid_cycle", k, nv * p + 2);
          chk("tbl_period", int'(bus.period), tbl[i].exp_p);
          chk("tbl_high", int'(bus.high_count), tbl[i].exp_h);
          chk("tbl_stalled", int'(bus.stalled), 0);
        end
      end
      chk("tbl_valid_count", nv, 3);
    end
    // high through reset release: the initial level must not count as an edge
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    for (int k = 0; k < 36; k++) begin
      cyc(k < 6 ? 1'b1 : !wv(k - 6, 5, 10), 0, 0);
      chk("hi_rel_valid", int'(bus.valid), int'(k == 23 || k == 33));
      if (bus.valid) begin
        chk("hi_rel_period", int'(bus.period), 10);
        chk("hi_rel_high", int'(bus.high_count), 5);
      end
    end
    // timeout after one measured period, then recovery with a period-8 wave
    start();
    for (int k = 0; k < 52; k++) begin
      cyc(k < 10 ? wv(k, 3, 6) && !(k >= 6 && k < 10 && 1'b0) || (k >= 6 && k < 10) : (k >= 40 ? wv(k - 40, 4, 8) : 1'b0), 0, 0);
      chk("tmo_valid", int'(bus.valid), int'(k == 8 || k == 50));
      if (k == 27 || k == 28 || k == 49 || k == 50)
        chk("tmo_stalled", int'(bus.stalled), int'(k == 28 || k == 49));
      if (k == 28 || k == 49) begin
        chk("tmo_hold_period", int'(bus.period), 6);
        chk("tmo_hold_high", int'(bus.high_count), 3);
      end
      if (k == 50) begin
        chk("tmo_rec_period", int'(bus.period), 8);
        chk("tmo_rec_high", int'(bus.high_count), 4);
      end
    end
    // clear coinciding with a rise discards the measurement
    start();
    for (int k = 0; k < 34; k++) begin
      cyc(wv(k, 3, 6), k == 20, 0);
      chk("clr_valid", int'(bus.valid), int'(k == 8 || k == 14 || k == 32));
      if (k == 20 || k == 32) begin
        chk("clr_period", int'(bus.period), 6);
        chk("clr_high", int'(bus.high_count), 3);
      end
    end
    // reset mid-measurement zeroes outputs, then a clean period follows
    start();
    for (int k = 0; k < 28; k++) begin
      cyc(wv(k, 3, 6), 0, k == 12);
      chk("mid_rst_valid", int'(bus.valid), int'(k == 8 || k == 26));
      if (k == 12) begin
        chk("mid_rst_period", int'(bus.period), 0);
        chk("mid_rst_high", int'(bus.high_count), 0);
        chk("mid_rst_stalled", int'(bus.stalled), 0);
      end
      if (k == 26) begin
        chk("mid_rst_rec_period", int'(bus.period), 6);
        chk("mid_rst_rec_high", int'(bus.high_count), 3);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
Measures a slow, divided clock or square wave produced elsewhere in the design, such as a clock-divider output.
- Synchronises the incoming waveform into the clock_in domain.
- Counts clock_in cycles between consecutive rising edges (period) and cycles spent high (high time).
- Reports each completed measurement with a one-cycle valid pulse.
- Flags a stalled input when no rising edge arrives within a timeout.

Parameters:
WIDTH, 23, bit width of the period and high-time counters and outputs.
TIMEOUT, 8388607, clock_in cycles without a rising edge before stalled asserts; must be at most 2^WIDTH-1 and at least 2.

Ports:
clock_in  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
sig_in  input  1  waveform under measurement; asynchronous to clock_in.
clear  input  1  synchronous soft clear; discards the measurement in progress.
period  output  WIDTH  clock_in cycles from one sig_in rising edge to the next (last completed).
high_count  output  WIDTH  clock_in cycles sig_in was high within that period.
valid  output  1  one-cycle pulse; period/high_count updated this cycle.
stalled  output  1  level; no rising edge within TIMEOUT cycles.

Behaviour:
Synchronisation:
- Chain s1 -> s2 -> s3, all reset to 0.
- rise = s2 & ~s3; s2 is the synchronised level.
- A sig_in transition is reflected in s2 two clock_in edges after it is first sampled.

States: WAIT_LOW, WAIT_RISE, MEASURE.
- WAIT_LOW: wait for s2 == 0, so a high level at reset release is never taken as an edge. Move to WAIT_RISE when s2 == 0.
- WAIT_RISE: on rise, load cnt = 1 and hcnt = 1, then move to MEASURE. No valid.
- MEASURE, no rise: cnt += 1; hcnt += s2.
- MEASURE, on rise:
  - register period <= cnt and high_count <= hcnt;
  - valid = 1 on the following cycle;
  - stalled <= 0;
  - reload cnt = 1 and hcnt = 1; stay in MEASURE.

Timeout:
- Applies in MEASURE and WAIT_RISE; cnt also counts in WAIT_RISE (loaded to 0 on entry).
- When cnt reaches TIMEOUT with no rise: stalled <= 1, go to WAIT_LOW.
- period and high_count hold their last values; no valid.

Arithmetic:
- cnt and hcnt never wrap; the timeout fires before overflow.
- hcnt <= cnt always.

Reset (synchronous, active-high):
- Outputs: period = 0, high_count = 0, valid = 0, stalled = 0.
- Internal: state = WAIT_LOW, counters = 0, sync flops = 0.
- Reset mid-measurement discards the partial count.

clear:
- Same effect as reset on state, counters and valid; period, high_count and stalled hold.
- clear wins over a simultaneous rise or timeout.
- reset wins over clear.

Latency: valid is asserted 1 cycle after the rise-detect cycle, i.e. 3 clock_in edges after sig_in is first sampled high.

Minimum period:
- Measures 2 cycles correctly when sig_in is synchronous and stable per cycle.
- Asynchronous inputs may show ±1 cycle jitter per edge.

Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
Package clock_meas_pkg holds:
- the state encoding (WAIT_LOW, WAIT_RISE, MEASURE);
- WIDTH and TIMEOUT defaults.

One sub-module, sync_edge_detect:
- 2-flop synchroniser plus edge register.
- Outputs the synchronised level and a rise pulse.
- Synchronous active-high reset.

Test Plan:
1. Reset, then sig_in high 3 cycles / low 3 cycles repeated (synchronous) -> first valid after second rise; period = 6, high_count = 3 on every subsequent valid; stalled = 0.
2. sig_in held high through reset release, then square wave of period 10 (high 5) -> no valid from the initial high level; first valid reports period = 10, high_count = 5.
3. TIMEOUT = 20: one rise, then sig_in held low -> stalled = 1 exactly 20 cycles after the cnt = 1 cycle. period holds its previous value. A later period-8 wave clears stalled at the first valid after two rises.
4. clear asserted mid-period in the same cycle as a rise -> no valid; state WAIT_LOW; outputs hold; next measurement begins after a low then rise.
5. Synchronous reset mid-measurement (cnt = 4) -> all outputs 0 on the next cycle; the following valid reports a full clean period.
6. Alternating sig_in every cycle (period 2, high 1) -> every valid reports period = 2, high_count = 1; valid pulses every 2 cycles.
